// File: rtl/stream_bitpack.sv
// Packs a byte-padded word stream densely (LSB-first) onto a wide AXI-Stream.
// Each image of WORDS_PER_IMAGE words ends with a zero-padded beat flagged by m_tlast.
module stream_bitpack #(
    parameter int WORDS_PER_IMAGE = 100,
    parameter int BITS_PER_WORD   = 13,
    parameter int OUT_BITS        = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [8*((BITS_PER_WORD+7)/8)-1:0]   s_tdata,
    input  logic                                 s_tvalid,
    output logic                                 s_tready,
    output logic [OUT_BITS-1:0]                  m_tdata,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output logic                                 m_tlast
);
    localparam int IN_W   = 8*((BITS_PER_WORD+7)/8);
    localparam int BUF_W  = OUT_BITS + BITS_PER_WORD;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int CNT_W  = (WORDS_PER_IMAGE > 1) ? $clog2(WORDS_PER_IMAGE) : 1;

    localparam logic [FILL_W-1:0] OUT_F    = FILL_W'(OUT_BITS);
    localparam logic [FILL_W-1:0] BITS_F   = FILL_W'(BITS_PER_WORD);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS_PER_IMAGE - 1);

    generate
        if (OUT_BITS < BITS_PER_WORD || BITS_PER_WORD < 1 || WORDS_PER_IMAGE < 1) begin : g_bad_params
            $error("stream_bitpack: need OUT_BITS >= BITS_PER_WORD >= 1 and WORDS_PER_IMAGE >= 1");
        end
        if (IN_W > BITS_PER_WORD) begin : g_pad
            // Byte padding above the word is deliberately dropped.
            logic unused_pad;
            assign unused_pad = ^s_tdata[IN_W-1:BITS_PER_WORD];
        end
    endgenerate

    logic [BUF_W-1:0]  data_reg, data_next;
    logic [FILL_W-1:0] fill_reg, fill_next, fill_base;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              pend_reg, pend_next;
    logic [BUF_W-1:0]  word_ext;
    logic              push, pop;

    assign m_tdata  = data_reg[OUT_BITS-1:0];
    assign m_tvalid = (fill_reg >= OUT_F) || (pend_reg && (fill_reg != '0));
    assign m_tlast  = pend_reg && (fill_reg <= OUT_F);
    // Gated by rst so the source is never acknowledged while reset is held.
    assign s_tready = !rst && !pend_reg && ((fill_reg < OUT_F) || m_tready);

    assign pop  = m_tvalid && m_tready;
    assign push = s_tvalid && s_tready;

    always_comb begin
        data_next = data_reg;
        fill_base = fill_reg;
        cnt_next  = cnt_reg;
        pend_next = pend_reg;
        word_ext  = {{OUT_BITS{1'b0}}, s_tdata[BITS_PER_WORD-1:0]};

        if (pop) begin
            data_next = data_reg >> OUT_BITS;
            if (m_tlast) begin
                fill_base = '0;
                pend_next = 1'b0;
            end else begin
                fill_base = fill_reg - OUT_F;
            end
        end

        // The new word lands just above whatever survives this cycle's pop.
        if (push) begin
            data_next = data_next | (word_ext << fill_base);
            if (cnt_reg == CNT_LAST) begin
                cnt_next  = '0;
                pend_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end

        fill_next = fill_base + (push ? BITS_F : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            fill_reg <= '0;
            cnt_reg  <= '0;
            pend_reg <= 1'b0;
        end else begin
            data_reg <= data_next;
            fill_reg <= fill_next;
            cnt_reg  <= cnt_next;
            pend_reg <= pend_next;
        end
    end
endmodule
